leiwand_rv32_bus_arbiter: RTL and testbench
===========================================

# leiwand_rv32_bus_arbiter

Two-master, one-slave arbiter for the leiwand_rv32 SoC memory bus. It sits between the CPU core's native valid/ready port (master 0) and a second requester (master 1, e.g. debug loader or DMA), and the shared SoC bus that fans out to ROM/flash, RAM, GPIO and IRQ-status decode. It grants the bus round-robin, holds the grant for exactly one transfer, and inserts a one-cycle release gap so registered slave `ready` flags drain. Optionally it terminates hung transfers with a timeout.

## Interface
- `XLEN`, 32: address/data width.
- `TIMEOUT`, 255: cycles in BUSY without `s_ready` before forced completion (1..255).
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous active-low reset.
- `m0_valid` in 1: master 0 request; held until `m0_ready`.
- `m0_addr` in XLEN: master 0 address.
- `m0_wdata` in XLEN: master 0 write data.
- `m0_wen` in 4: master 0 byte write enables (0 = read).
- `m0_ready` out 1: one-cycle completion pulse to master 0.
- `m0_rdata` out XLEN: read data, valid while `m0_ready`=1.
- `m1_valid`, `m1_addr`, `m1_wdata`, `m1_wen`, `m1_ready`, `m1_rdata`: same for master 1.
- `s_valid` out 1: request to shared bus.
- `s_addr`, `s_wdata` out XLEN; `s_wen` out 4: muxed from owner.
- `s_ready` in 1: shared-bus completion (OR of slave readies).
- `s_rdata` in XLEN: shared-bus read data.
- `owner` out 1: current/last grantee.
- `bus_err` out 1: sticky timeout flag.
- `err_addr` out XLEN: address of first timed-out transfer.
- `err_clr` in 1: clears `bus_err`/`err_addr`.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: `s_valid`=0. If any `mX_valid`, register winner into `owner`, go BUSY. Only one requester → it wins. Both → the master that is not `last` wins; `last` updates to winner on grant. Reset `last`=1, so master 0 wins the first tie.
- BUSY: `s_valid`=1, `s_addr/s_wdata/s_wen` driven combinationally from owner's inputs. When `s_ready`=1: `m{owner}_ready`=1 combinationally, `m{owner}_rdata`=`s_rdata`; go RELEASE.
- RELEASE: `s_valid`=0 for exactly one cycle; then IDLE.
- Non-owner `mX_ready`=0 always; non-owner `mX_rdata`=0.
- Owner dropping `valid` during BUSY is a protocol violation; arbiter stays BUSY until `s_ready` or timeout.
- `s_ready` outside BUSY is ignored.
- `err_clr` same cycle as a new timeout: set wins.

## Timing
- Reset: state=IDLE, `owner`=0, `last`=1, `s_valid`=0, `s_addr/s_wdata`=0, `s_wen`=0, both `mX_ready`=0, `bus_err`=0, `err_addr`=0, timeout counter=0.
- Grant latency: `mX_valid` seen in IDLE at edge n → `s_valid`=1 from cycle n+1.
- Completion: zero added latency; `mX_ready` same cycle as `s_ready`.
- Minimum transfer period per master: request → grant (1) + slave latency (≥1) + RELEASE (1); back-to-back alternating masters each get a grant every other transfer.
- Reset mid-BUSY: all outputs return to reset values asynchronously; no `ready` issued for the aborted transfer.

## Configuration
- `LEIWAND_BUS_ARB_TIMEOUT_EN` defined: 8-bit counter clears on entering BUSY, increments each BUSY cycle without `s_ready`. When counter==`TIMEOUT` and `s_ready`=0: `m{owner}_ready`=1, `m{owner}_rdata`=0, `bus_err`←1, `err_addr`←`s_addr` if `bus_err` was 0; go RELEASE. `s_ready` on that same cycle takes priority (normal completion, no error).
- Not defined: no counter; BUSY waits indefinitely; `bus_err`=0, `err_addr`=0 constant; `err_clr` ignored.

## Test plan
- Single read: m0 reads 0x20400004, slave returns 0xDEADBEEF one cycle after `s_valid` → `m0_ready` pulse with 0xDEADBEEF, `s_valid` low one cycle after.
- Tie: both request at same edge after reset → m0 granted first, then m1 after RELEASE; `owner` 0 then 1.
- Fairness: both hold requests for 6 transfers → grants alternate 0,1,0,1,0,1; no master starves.
- Write passthrough: m1 writes 0x00000003 to 0x30000000 with `wen`=0xF → `s_wdata`=3, `s_wen`=0xF while BUSY; `m0_ready` stays 0.
- Timeout (macro on, `TIMEOUT`=16): m0 reads unmapped 0x50000000, `s_ready` never → `m0_ready` after 16 BUSY cycles with rdata 0, `bus_err`=1, `err_addr`=0x50000000; `err_clr` pulse → both cleared.
- Async reset during BUSY → `s_valid`, `mX_ready` drop immediately; next request granted normally.

Source files
------------

// File: rtl/leiwand_rv32_bus_arbiter.sv
// leiwand_rv32_bus_arbiter: round-robin two-master to one-slave arbiter for the leiwand_rv32 SoC bus.
// Defining LEIWAND_BUS_ARB_TIMEOUT_EN adds a hung-transfer timeout with a sticky bus_err/err_addr.
module leiwand_rv32_bus_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            m0_valid,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [3:0]      m0_wen,
    output logic            m0_ready,
    output logic [XLEN-1:0] m0_rdata,
    input  logic            m1_valid,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [3:0]      m1_wen,
    output logic            m1_ready,
    output logic [XLEN-1:0] m1_rdata,
    output logic            s_valid,
    output logic [XLEN-1:0] s_addr,
    output logic [XLEN-1:0] s_wdata,
    output logic [3:0]      s_wen,
    input  logic            s_ready,
    input  logic [XLEN-1:0] s_rdata,
    output logic            owner,
    output logic            bus_err,
    output logic [XLEN-1:0] err_addr,
    input  logic            err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RELEASE
    } state_t;

    state_t          r_state;
    logic            r_owner;
    logic            r_last;
    logic            w_busy;
    logic            w_any_req;
    logic            w_winner;
    logic            w_timeout;
    logic            w_done;
    logic [XLEN-1:0] w_rdata;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_any_req = m0_valid | m1_valid;
    // On a tie the master that did not win the previous grant gets the bus.
    assign w_winner  = (m0_valid & m1_valid) ? ~r_last : m1_valid;

`ifdef LEIWAND_BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    logic [7:0]      r_cnt;
    logic            r_bus_err;
    logic [XLEN-1:0] r_err_addr;

    // A real s_ready on the deadline cycle completes normally.
    assign w_timeout = w_busy & ~s_ready & (r_cnt == LP_TIMEOUT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= 8'd0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_cnt <= 8'd0;
        end else if (w_busy && !w_done) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Only the first timed-out address is kept until software clears it; set beats clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            if (!r_bus_err) begin
                r_err_addr <= s_addr;
            end
        end else if (err_clr) begin
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
        end
    end

    assign bus_err  = r_bus_err;
    assign err_addr = r_err_addr;
`else
    logic w_unused;

    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
    assign err_addr  = '0;
    assign w_unused  = err_clr ^ (TIMEOUT != 0);
`endif

    assign w_done = w_busy & (s_ready | w_timeout);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_last  <= w_winner;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_state <= ST_RELEASE;
                    end
                end
                // One dead cycle lets registered slave ready flags fall before the next grant.
                ST_RELEASE: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_valid = w_busy;
    assign s_addr  = !w_busy ? '0 : (r_owner ? m1_addr  : m0_addr);
    assign s_wdata = !w_busy ? '0 : (r_owner ? m1_wdata : m0_wdata);
    assign s_wen   = !w_busy ? '0 : (r_owner ? m1_wen   : m0_wen);

    // A forced completion returns zero data.
    assign w_rdata  = s_ready ? s_rdata : '0;
    assign m0_ready = w_done & ~r_owner;
    assign m1_ready = w_done &  r_owner;
    assign m0_rdata = m0_ready ? w_rdata : '0;
    assign m1_rdata = m1_ready ? w_rdata : '0;
    assign owner    = r_owner;

endmodule

// File: tb/tb_leiwand_rv32_bus_arbiter.sv
// Scoreboard bench for leiwand_rv32_bus_arbiter: per-master request drivers, a slave model,
// and a monitor that checks every completion against queued expectations.
module tb_leiwand_rv32_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wen = '0, m1_wen = '0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wen;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        owner, bus_err;
    logic [31:0] err_addr;
    logic        err_clr = 1'b0;

    leiwand_rv32_bus_arbiter #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wen(m0_wen),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wen(m1_wen),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .owner(owner), .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
    } req_t;

    req_t        q0[$], q1[$];
    logic [31:0] exp_d0[$], exp_d1[$];
    bit          exp_own[$];
    int          checks = 0;
    int          errors = 0;
    bit          hang = 1'b0;
    int          lat_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input bit m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] we, input logic [31:0] exp_rd);
        req_t r;
        r.addr = a; r.wdata = wd; r.wen = we;
        if (m) begin q1.push_back(r); exp_d1.push_back(exp_rd); end
        else   begin q0.push_back(r); exp_d0.push_back(exp_rd); end
    endtask

    // Slave: one wait cycle then ready, data derived from the address unless hung.
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h2040_0004) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
    endfunction

    always @(negedge clk) begin
        #1;
        if (s_valid && !hang) begin
            if (lat_cnt == 1) begin
                s_ready = 1'b1; s_rdata = rdata_of(s_addr); lat_cnt = 0;
            end else begin
                s_ready = 1'b0; s_rdata = '0; lat_cnt++;
            end
        end else begin
            s_ready = 1'b0; s_rdata = '0; lat_cnt = 0;
        end
    end

    // Master drivers: drop valid on completion, immediately present the next queued request.
    always @(negedge clk) begin
        req_t r;
        #4;
        if (m0_valid && m0_ready) m0_valid = 1'b0;
        if (!m0_valid && q0.size() > 0) begin
            r = q0.pop_front();
            m0_addr = r.addr; m0_wdata = r.wdata; m0_wen = r.wen; m0_valid = 1'b1;
        end
    end

    always @(negedge clk) begin
        req_t r;
        #4;
        if (m1_valid && m1_ready) m1_valid = 1'b0;
        if (!m1_valid && q1.size() > 0) begin
            r = q1.pop_front();
            m1_addr = r.addr; m1_wdata = r.wdata; m1_wen = r.wen; m1_valid = 1'b1;
        end
    end

    // Monitor
    always @(negedge clk) begin
        bit g;
        logic [31:0] e;
        #3;
        if (m0_ready && m1_ready) begin
            chk("both_ready", {m0_ready, m1_ready}, 2'b00);
        end else if (m0_ready || m1_ready) begin
            g = m1_ready;
            if (exp_own.size() == 0) begin
                chk("unexpected_ready", 32'(g) + 32'd1, 32'd0);
            end else begin
                chk("grant_order", 32'(g), 32'(exp_own.pop_front()));
                chk("owner_out", 32'(owner), 32'(g));
                if (g) begin
                    e = (exp_d1.size() > 0) ? exp_d1.pop_front() : 32'hXXXX_XXXX;
                    chk("m1_rdata", m1_rdata, e);
                    chk("m0_rdata_idle", m0_rdata, 32'h0);
                end else begin
                    e = (exp_d0.size() > 0) ? exp_d0.pop_front() : 32'hXXXX_XXXX;
                    chk("m0_rdata", m0_rdata, e);
                    chk("m1_rdata_idle", m1_rdata, 32'h0);
                end
            end
        end
    end

    task automatic drain(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #6;
            if (q0.size() == 0 && q1.size() == 0 && !m0_valid && !m1_valid && exp_own.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_s_valid(input string nm);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #3;
            if (s_valid) break;
        end
        chk(nm, 32'(s_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;

        // Reset state
        #12;
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wen", 32'(s_wen), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_ready", {m0_ready, m1_ready}, 2'b00);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_err_addr", err_addr, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Tie straight after reset: master 0 first, then master 1
        issue(0, 32'h2040_0004, 32'h0, 4'h0, 32'hDEAD_BEEF);
        issue(1, 32'h3000_0000, 32'h0, 4'h0, 32'h6A5A_5A5A);
        exp_own.push_back(1'b0); exp_own.push_back(1'b1);
        drain("tie_drain");

        // Fairness: both keep requesting, grants alternate
        issue(0, 32'h0000_1000, 32'h0, 4'h0, 32'h5A5A_4A5A);
        issue(0, 32'h0000_1004, 32'h0, 4'h0, 32'h5A5A_4A5E);
        issue(0, 32'h0000_1008, 32'h0, 4'h0, 32'h5A5A_4A52);
        issue(1, 32'h0000_2000, 32'h0, 4'h0, 32'h5A5A_7A5A);
        issue(1, 32'h0000_2004, 32'h0, 4'h0, 32'h5A5A_7A5E);
        issue(1, 32'h0000_2008, 32'h0, 4'h0, 32'h5A5A_7A52);
        for (int i = 0; i < 3; i++) begin
            exp_own.push_back(1'b0); exp_own.push_back(1'b1);
        end
        drain("fair_drain");

        // Single read: one wait cycle, ready with data, then a low s_valid cycle
        issue(0, 32'h2040_0004, 32'h0, 4'h0, 32'hDEAD_BEEF);
        exp_own.push_back(1'b0);
        n = 0; got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #3;
            if (m0_ready) begin got = 1'b1; break; end
            if (s_valid) n++;
        end
        chk("single_ready_seen", 32'(got), 32'd1);
        chk("single_latency", n, 32'd1);
        @(negedge clk); #3;
        chk("single_release", 32'(s_valid), 32'd0);
        drain("single_drain");

        // Write passthrough from master 1
        issue(1, 32'h3000_0000, 32'h0000_0003, 4'hF, 32'h6A5A_5A5A);
        exp_own.push_back(1'b1);
        wait_s_valid("wr_s_valid");
        chk("wr_s_addr", s_addr, 32'h3000_0000);
        chk("wr_s_wdata", s_wdata, 32'h0000_0003);
        chk("wr_s_wen", 32'(s_wen), 32'hF);
        chk("wr_owner", 32'(owner), 32'd1);
        chk("wr_m0_ready", 32'(m0_ready), 32'd0);
        drain("wr_drain");

`ifdef LEIWAND_BUS_ARB_TIMEOUT_EN
        // Hung read forced complete after 16 BUSY cycles
        hang = 1'b1;
        issue(0, 32'h5000_0000, 32'h0, 4'h0, 32'h0);
        exp_own.push_back(1'b0);
        wait_s_valid("to_s_valid");
        n = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m0_ready) begin got = 1'b1; break; end
            n++;
            @(negedge clk); #3;
        end
        chk("to_ready_seen", 32'(got), 32'd1);
        chk("to_busy_cycles", n, 32'd16);
        @(negedge clk); #3;
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_err_addr", err_addr, 32'h5000_0000);
        hang = 1'b0;
        drain("to_drain");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #3;
        chk("clr_bus_err", 32'(bus_err), 32'd0);
        chk("clr_err_addr", err_addr, 32'h0);
`else
        chk("noto_bus_err", 32'(bus_err), 32'd0);
        chk("noto_err_addr", err_addr, 32'h0);
`endif

        // Async reset in the middle of a hung transfer
        hang = 1'b1;
        issue(1, 32'h0000_2000, 32'h0, 4'h0, 32'h0);
        void'(exp_d1.pop_back());
        wait_s_valid("rstb_s_valid");
        @(negedge clk);
        @(negedge clk);
        #5;
        resetn = 1'b0;
        m1_valid = 1'b0;
        #1;
        chk("rstb_s_valid_low", 32'(s_valid), 32'd0);
        chk("rstb_ready_low", {m0_ready, m1_ready}, 2'b00);
        chk("rstb_owner", 32'(owner), 32'd0);
        chk("rstb_s_addr", s_addr, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        hang = 1'b0;
        issue(0, 32'h0000_1000, 32'h0, 4'h0, 32'h5A5A_4A5A);
        exp_own.push_back(1'b0);
        drain("post_rst_drain");

        chk("exp_d0_empty", exp_d0.size(), 32'd0);
        chk("exp_d1_empty", exp_d1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
